// File: rtl/main.sv
// rtl/main.sv - three-stage signed multiply-add pipeline, y = a*b + c, shared clock enable

module main #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int C_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic signed [A_WIDTH-1:0] a,
    input  logic signed [B_WIDTH-1:0] b,
    input  logic signed [C_WIDTH-1:0] c,
    input  logic                      en,
    output logic signed [C_WIDTH-1:0] y
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int S_WIDTH = (P_WIDTH > C_WIDTH) ? P_WIDTH : C_WIDTH;

    logic signed [A_WIDTH-1:0] r_a;
    logic signed [B_WIDTH-1:0] r_b;
    logic signed [C_WIDTH-1:0] r_c;
    logic signed [P_WIDTH-1:0] r_m;
    logic signed [C_WIDTH-1:0] r_c2;
    logic signed [C_WIDTH-1:0] r_y;

    logic signed [P_WIDTH-1:0] w_prod;
    logic signed [S_WIDTH-1:0] w_m_ext;
    logic signed [S_WIDTH-1:0] w_c_ext;
    logic signed [S_WIDTH-1:0] w_sum;

    // Operands widened first so the product keeps full precision.
    always_comb begin
        w_prod  = P_WIDTH'(r_a) * P_WIDTH'(r_b);
        w_m_ext = S_WIDTH'(r_m);
        w_c_ext = S_WIDTH'(r_c2);
        w_sum   = w_m_ext + w_c_ext;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a  <= '0;
            r_b  <= '0;
            r_c  <= '0;
            r_m  <= '0;
            r_c2 <= '0;
            r_y  <= '0;
        end else if (en) begin
            r_a  <= a;
            r_b  <= b;
            r_c  <= c;
            r_m  <= w_prod;
            r_c2 <= r_c;
            // Low bits only: the sum wraps modulo 2^C_WIDTH.
            r_y  <= w_sum[C_WIDTH-1:0];
        end
    end

    assign y = r_y;

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - directed vector bench for the multiply-add pipeline

module tb_main;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic signed [7:0]  a = '0;
    logic signed [7:0]  b = '0;
    logic signed [15:0] c = '0;
    logic               en = 1'b0;
    logic signed [15:0] y;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic signed [7:0]  a;
        logic signed [7:0]  b;
        logic signed [15:0] c;
        logic signed [15:0] exp_y;
    } vec_t;

    vec_t vecs[8];

    main #(.A_WIDTH(8), .B_WIDTH(8), .C_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .c     (c),
        .en    (en),
        .y     (y)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic signed [15:0] exp_y);
        total++;
        if (y !== exp_y) begin
            bad++;
            $display("FAIL %s: y=%0d (0x%h) expected %0d (0x%h)", name, y, y, exp_y, exp_y);
        end
    endtask

    task automatic set_in(input int va, input int vb, input int vc);
        a = 8'(va);
        b = 8'(vb);
        c = 16'(vc);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            check("reset_y", 16'sd0);
        end
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'sd127,  8'sd1,    16'sh0000, 16'sh007F};
        vecs[1] = '{-8'sd128, -8'sd128, 16'sd0,    16'sd16384};
        vecs[2] = '{-8'sd128, 8'sd127,  -16'sd1,   -16'sd16257};
        vecs[3] = '{8'sd127,  8'sd127,  16'sd32767, 16'shBF00};
        vecs[4] = '{8'sd1,    8'sd1,    16'sd0,    16'sd1};
        vecs[5] = '{8'sd2,    8'sd3,    16'sd4,    16'sd10};
        vecs[6] = '{-8'sd5,   8'sd6,    16'sd7,    -16'sd23};
        vecs[7] = '{8'sd10,   -8'sd10,  16'sd100,  16'sd0};

        // Constant stream after a 3-cycle reset: zeros during fill, then -23.
        en = 1'b1;
        set_in(127, 1, -150);
        do_reset(3);
        for (int i = 1; i <= 5; i++) begin
            step();
            check(i < 3 ? "fill_zero" : "const_out", i < 3 ? 16'sd0 : 16'shFFE9);
        end

        // Back-to-back streaming of the vector table, one result per cycle.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) set_in(vecs[i].a, vecs[i].b, vecs[i].c);
            else       set_in(0, 0, 0);
            step();
            if (i >= 2) check("table_stream", vecs[i-2].exp_y);
        end

        // Enable stall mid-pipeline: output frozen, then remaining results in order.
        do_reset(1);
        en = 1'b1;
        set_in(1, 1, 0);     step();
        set_in(2, 3, 4);     step();
        set_in(-5, 6, 7);    step();
        check("stall_pre", 16'sd1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(33 + i, -7, 999);
            step();
            check("stall_hold", 16'sd1);
        end
        en = 1'b1;
        set_in(10, -10, 100); step();
        check("stall_resume0", 16'sd10);
        set_in(0, 0, 0);      step();
        check("stall_resume1", -16'sd23);
        step();
        check("stall_resume2", 16'sd0);

        // Reset wins over enable while the pipeline holds nonzero data.
        set_in(127, 127, 5);  step();
        set_in(-128, 3, 9);   step();
        set_in(4, 4, 4);      step();
        check("prefull", 16'sd16134);
        reset = 1'b1;
        step();
        check("reset_prio", 16'sd0);
        reset = 1'b0;
        set_in(2, 3, 4);      step();
        check("post_rst0", 16'sd0);
        set_in(0, 0, 0);      step();
        check("post_rst1", 16'sd0);
        step();
        check("post_rst2", 16'sd10);

        // Enable low through and after reset: nothing loads until en returns.
        en = 1'b0;
        reset = 1'b1;
        set_in(127, 127, 0);
        step();
        check("rst_en0", 16'sd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en0_hold", 16'sd0);
        end
        en = 1'b1;
        set_in(0, 0, 5);
        step();
        check("en1_fill0", 16'sd0);
        step();
        check("en1_fill1", 16'sd0);
        step();
        check("en1_out", 16'sd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
